seq_mul_approx: RTL and testbench
=================================

Name: seq_mul_approx

Overview:
- Parametrised, iterative unsigned multiplier.
- Successor to the team's fixed 8x8 combinational array multipliers: operand width and bits-per-cycle are configurable.
- Adds valid/ready handshakes, a runtime exact/truncated approximation mode and optional early termination.
- Sits in the approximate-arithmetic library as a low-area, low-power alternative for datapaths that tolerate multi-cycle latency.

Parameters:
- WIDTH, 8: operand width in bits; result is 2*WIDTH.
- BPC, 1: multiplier bits consumed per cycle. Must divide WIDTH; legal values 1, 2, 4.
- TRUNC_K, 4: number of low partial-product columns dropped in approximate mode. Range 0..2*WIDTH-1.
- EARLY_EXIT, 0: 1 = finish as soon as the remaining multiplier bits are all zero.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  multiplicand (unsigned)
- in_b  in  WIDTH  multiplier (unsigned)
- in_approx  in  1  1 = truncated mode for this operation; sampled at accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_p  out  2*WIDTH  product
- out_cycles  out  8  number of BUSY cycles used by this operation

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, out_p = 0, out_cycles = 0.
  - Internal accumulator, A/B shadow registers and counter are cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid&&in_ready, capture in_a, in_b, in_approx; accumulator = 0; iteration count = 0; next state BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle processes the BPC least-significant bits of the B shadow register. For bit j of the chunk, at global index i = count*BPC + j: if b_i = 1, add (A << i) & M to the accumulator.
  - M = all-ones when approx = 0. When approx = 1, M is all-ones with bits [TRUNC_K-1:0] cleared.
  - Then B shadow >>= BPC and count++.
  - Go to DONE after count reaches WIDTH/BPC. With EARLY_EXIT = 1, also go to DONE when the shifted B shadow is zero.
  - At least one BUSY cycle always occurs (B = 0 still takes 1 cycle).
- DONE:
  - out_valid = 1; out_p = accumulator; out_cycles = BUSY cycles used.
  - On out_ready, next state IDLE and out_valid drops the following cycle.
  - While out_ready = 0, out_p and out_cycles hold stable and in_ready = 0. There is no new accept until the block is back in IDLE.
- Latency:
  - Accept edge at cycle t; out_valid high from cycle t+N, where N = WIDTH/BPC.
  - With EARLY_EXIT = 1, N = max(1, ceil((msb_index(b)+1)/BPC)).
  - Throughput: one result per N+2 cycles minimum.
- Arithmetic:
  - Accumulator is 2*WIDTH bits. The exact product never overflows it; truncated mode is always ≤ the exact product.
  - Exact mode must match A*B bit-for-bit.
  - Truncated mode must match sum over i of b_i*((A<<i)&M).
- Input changes on in_a/in_b/in_approx outside the accept cycle have no effect.
- rst asserted in any state: next cycle is IDLE with reset values. An in-flight operation is discarded and no out_valid is produced for it.
- in_valid while not in IDLE is ignored (not queued).

Decomposition:
- Package seq_mul_approx_pkg holds:
  - state enum (IDLE, BUSY, DONE);
  - function trunc_mask(approx, TRUNC_K), returning the 2*WIDTH mask;
  - parameter legality checks (WIDTH % BPC == 0, TRUNC_K < 2*WIDTH), as elaboration assertions.
- Sub-module seq_mul_pp_step (combinational) holds one iteration. Inputs: A, B chunk, base index, mask, accumulator. Output: accumulator + masked partial-product sum of BPC rows.
- FSM, counter and handshake stay in the top.

Test Plan:
- Exact max, WIDTH=8, BPC=1, approx=0: a=255, b=255 -> out_p=65025, out_cycles=8, out_valid 8 cycles after accept.
- Truncated, TRUNC_K=4: a=255, b=255, approx=1 -> out_p=64976 (error 49); a=3, b=5, approx=1 -> out_p=0.
- Early exit, EARLY_EXIT=1, BPC=1: b=1, a=200 -> out_p=200, out_cycles=1; b=0 -> out_p=0, out_cycles=1; b=0x80 -> out_cycles=8.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands driven -> out_p stable, in_ready=0, no new accept. Release -> IDLE, then the new operands are accepted.
- Reset mid-op: assert rst at the 3rd BUSY cycle of a=17, b=13 -> next cycle IDLE, out_valid=0, out_p=0. Next operation a=17, b=13 -> 221.
- Random sweep, BPC ∈ {1, 2, 4}, WIDTH ∈ {8, 16}, 10k operations per config with random backpressure -> all results match the exact/truncated reference model; out_cycles matches the latency formula.

Source files
------------

// File: rtl/seq_mul_approx_pkg.sv
// Shared types and helpers for the iterative approximate multiplier.
//   state_t    : controller states
//   MAX_PW     : widest product supported by the mask helper
//   trunc_mask : product-width mask, low trunc_k columns cleared in approx mode
package seq_mul_approx_pkg;

  localparam int MAX_PW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Callers cast the result down to their own 2*WIDTH product width.
  function automatic logic [MAX_PW-1:0] trunc_mask(input logic approx, input int trunc_k);
    logic [MAX_PW-1:0] m;
    m = '1;
    if (approx) m = m << trunc_k;
    return m;
  endfunction

endpackage

// File: rtl/seq_mul_pp_step.sv
// One multiplier iteration (combinational).
//   a       : multiplicand
//   b_chunk : BPC multiplier bits for this iteration, LSB = row at index base
//   base    : global bit index of b_chunk[0]
//   mask    : column mask applied to every partial-product row
//   acc     : running accumulator
//   acc_nxt : acc + sum of masked rows
module seq_mul_pp_step #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [BPC-1:0]     b_chunk,
  input  logic [7:0]         base,
  input  logic [2*WIDTH-1:0] mask,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_nxt
);
  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]          a_ext;
  logic [BPC-1:0][PW-1:0] pp;

  assign a_ext = {{WIDTH{1'b0}}, a};

  // Mask applies per row so truncated mode drops low columns of each row,
  // not of the final sum.
  for (genvar j = 0; j < BPC; j++) begin : g_row
    assign pp[j] = b_chunk[j] ? ((a_ext << (base + 8'(j))) & mask) : '0;
  end

  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < BPC; j++) acc_nxt = acc_nxt + pp[j];
  end

endmodule

// File: rtl/seq_mul_approx.sv
// Iterative unsigned multiplier with exact / column-truncated mode.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (accepted only in IDLE)
//   in_a, in_b, in_approx: operands and mode, sampled at accept
//   out_valid/out_ready  : result handshake (held in DONE until taken)
//   out_p                : 2*WIDTH product
//   out_cycles           : BUSY cycles used by the operation
module seq_mul_approx
  import seq_mul_approx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BPC        = 1,
  parameter int TRUNC_K    = 4,
  parameter int EARLY_EXIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [7:0]         out_cycles
);
  localparam int PW = 2 * WIDTH;
  localparam int N  = WIDTH / BPC;

  if ((WIDTH % BPC) != 0 || !(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_bpc
    $error("seq_mul_approx: BPC must be 1, 2 or 4 and divide WIDTH");
  end
  if (TRUNC_K < 0 || TRUNC_K >= PW) begin : g_bad_trunc
    $error("seq_mul_approx: TRUNC_K out of range");
  end
  if (PW > MAX_PW) begin : g_bad_width
    $error("seq_mul_approx: WIDTH too large");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, b_shift;
  logic [PW-1:0]    acc, acc_step, mask;
  logic [7:0]       cnt, cnt_inc;
  logic             approx_q, last;

  assign mask    = PW'(trunc_mask(approx_q, TRUNC_K));
  assign b_shift = b_q >> BPC;
  assign cnt_inc = cnt + 8'd1;
  // Early exit looks at the shifted shadow, so B = 0 still spends one cycle.
  assign last    = (cnt_inc == 8'(N)) || ((EARLY_EXIT != 0) && (b_shift == '0));

  seq_mul_pp_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
    .a       (a_q),
    .b_chunk (b_q[BPC-1:0]),
    .base    (8'(cnt * BPC)),
    .mask    (mask),
    .acc     (acc),
    .acc_nxt (acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      approx_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= in_a;
          b_q      <= in_b;
          approx_q <= in_approx;
          acc      <= '0;
          cnt      <= '0;
        end
        BUSY: begin
          acc <= acc_step;
          b_q <= b_shift;
          cnt <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  // Result and count stay registered, so they hold through DONE backpressure.
  assign out_p      = acc;
  assign out_cycles = cnt;

endmodule

// File: tb/tb_seq_mul_approx.sv
// Directed + small random check of seq_mul_approx (WIDTH=8, TRUNC_K=4).
// Instance 0: BPC=1 exact latency; 1: BPC=1 early exit; 2: BPC=4.
module tb_seq_mul_approx;
  logic clk = 1'b0;
  logic rst;
  logic [2:0]       in_valid, in_ready, in_approx, out_valid, out_ready;
  logic [2:0][7:0]  in_a, in_b, out_cycles;
  logic [2:0][15:0] out_p;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_mul_approx #(.WIDTH(8), .BPC(1), .TRUNC_K(4), .EARLY_EXIT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_approx(in_approx[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_p(out_p[0]), .out_cycles(out_cycles[0]));

  seq_mul_approx #(.WIDTH(8), .BPC(1), .TRUNC_K(4), .EARLY_EXIT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_approx(in_approx[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_p(out_p[1]), .out_cycles(out_cycles[1]));

  seq_mul_approx #(.WIDTH(8), .BPC(4), .TRUNC_K(4), .EARLY_EXIT(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_approx(in_approx[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_p(out_p[2]), .out_cycles(out_cycles[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Reference: sum of rows, each masked to drop columns [3:0] in approx mode.
  function automatic logic [15:0] ref_p(input logic [7:0] a, input logic [7:0] b, input logic ap);
    logic [15:0] s, m;
    s = '0;
    m = ap ? 16'hfff0 : 16'hffff;
    for (int i = 0; i < 8; i++)
      if (b[i]) s = s + (({8'h00, a} << i) & m);
    return s;
  endfunction

  function automatic int ref_cyc(input logic [7:0] b, input int bpc, input bit ee);
    int msb;
    if (!ee) return 8 / bpc;
    msb = -1;
    for (int i = 0; i < 8; i++) if (b[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + bpc) / bpc;
  endfunction

  task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic ap,
                       input int stall, output logic [15:0] p, output logic [7:0] cyc,
                       output int lat);
    int guard;
    @(negedge clk);
    in_a[d] = a; in_b[d] = b; in_approx[d] = ap; in_valid[d] = 1'b1;
    guard = 0;
    while (!in_ready[d] && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    // Scramble inputs after accept; they must not affect the operation.
    in_valid[d] = 1'b0; in_a[d] = ~a; in_b[d] = ~b; in_approx[d] = ~ap;
    lat = 0;
    while (!out_valid[d] && lat < 100) begin @(posedge clk); #1; lat++; end
    p   = out_p[d];
    cyc = out_cycles[d];
    repeat (stall) @(posedge clk);
    #1 chk("hold_p", out_p[d], p);
    @(negedge clk) out_ready[d] = 1'b1;
    @(posedge clk); #1 out_ready[d] = 1'b0;
    chk("valid_drop", out_valid[d], 0);
  endtask

  task automatic run(input string tag, input int d, input logic [7:0] a, input logic [7:0] b,
                     input logic ap, input int stall, input logic [15:0] ep, input int ec);
    logic [15:0] p;
    logic [7:0]  cyc;
    int          lat;
    do_op(d, a, b, ap, stall, p, cyc, lat);
    chk({tag, "_p"}, p, ep);
    chk({tag, "_cyc"}, cyc, ec);
    chk({tag, "_lat"}, lat, ec);
  endtask

  initial begin
    int guard;
    int bpc_of[3];
    bit ee_of[3];
    bpc_of = '{1, 1, 4};
    ee_of  = '{0, 1, 0};
    rst = 1'b1;
    in_valid = '0; out_ready = '0; in_approx = '0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", in_ready[0], 1);
    chk("rst_valid", out_valid[0], 0);
    chk("rst_p", out_p[0], 0);
    chk("rst_cyc", out_cycles[0], 0);

    // Directed vectors
    run("ex_max",   0, 8'd255, 8'd255, 1'b0, 0, 16'd65025, 8);
    run("tr_max",   0, 8'd255, 8'd255, 1'b1, 2, 16'd64976, 8);
    run("tr_small", 0, 8'd3,   8'd5,   1'b1, 0, 16'd0,     8);
    run("ee_b1",    1, 8'd200, 8'd1,   1'b0, 0, 16'd200,   1);
    run("ee_b0",    1, 8'd77,  8'd0,   1'b0, 0, 16'd0,     1);
    run("ee_b80",   1, 8'd3,   8'h80,  1'b0, 0, 16'd384,   8);
    run("ee_tr",    1, 8'd255, 8'd3,   1'b1, 1, 16'd736,   2);
    run("b4_ex",    2, 8'd255, 8'd255, 1'b0, 0, 16'd65025, 2);
    run("b4_tr",    2, 8'd255, 8'd255, 1'b1, 0, 16'd64976, 2);
    run("b4_mid",   2, 8'd18,  8'd52,  1'b0, 3, 16'd936,   2);

    // Backpressure: new operands stay presented while the result is held
    @(negedge clk);
    in_a[0] = 8'd10; in_b[0] = 8'd20; in_approx[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_a[0] = 8'd7; in_b[0] = 8'd9;
    guard = 0;
    while (!out_valid[0] && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("bp_first", out_p[0], 200);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_p", out_p[0], 200);
      chk("bp_hold_rdy", in_ready[0], 0);
      chk("bp_hold_vld", out_valid[0], 1);
    end
    @(negedge clk) out_ready[0] = 1'b1;
    @(posedge clk); #1 out_ready[0] = 1'b0;
    chk("bp_idle_rdy", in_ready[0], 1);
    chk("bp_idle_vld", out_valid[0], 0);
    @(posedge clk); #1 in_valid[0] = 1'b0;
    chk("bp_accept", in_ready[0], 0);
    guard = 0;
    while (!out_valid[0] && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("bp_second", out_p[0], 63);
    chk("bp_second_cyc", out_cycles[0], 8);
    @(negedge clk) out_ready[0] = 1'b1;
    @(posedge clk); #1 out_ready[0] = 1'b0;

    // Reset during the third BUSY cycle
    @(negedge clk);
    in_a[0] = 8'd17; in_b[0] = 8'd13; in_approx[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1 in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_rdy", in_ready[0], 1);
    chk("mid_rst_vld", out_valid[0], 0);
    chk("mid_rst_p", out_p[0], 0);
    chk("mid_rst_cyc", out_cycles[0], 0);
    repeat (10) @(posedge clk);
    #1 chk("mid_rst_no_vld", out_valid[0], 0);
    run("after_rst", 0, 8'd17, 8'd13, 1'b0, 0, 16'd221, 8);

    // Random sweep across the three configurations
    for (int i = 0; i < 240; i++) begin
      int d;
      logic [7:0] a, b;
      logic ap;
      d  = i % 3;
      a  = 8'($urandom);
      b  = 8'($urandom);
      if (i % 7 == 0) b = b >> $urandom_range(0, 7);
      ap = 1'($urandom);
      run("rnd", d, a, b, ap, $urandom_range(0, 3), ref_p(a, b, ap),
          ref_cyc(b, bpc_of[d], ee_of[d]));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=stalled want=finish");
    $fatal(1, "timeout");
  end

endmodule
